// File: rtl/encode32_arbiter.sv
// Collects 32 event strobes into a pending vector and issues one 5-bit source index
// at a time over a valid/ready handshake, with fixed or rotating priority.
module encode32_arbiter #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic [31:0] mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] pending,
  output logic        lost
);

  logic [31:0] pending_r;
  logic        out_valid_r;
  logic [4:0]  out_idx_r;
  logic        lost_r;
  logic [4:0]  ptr_r;

  logic        load_s;
  logic [31:0] elig_s;
  logic [4:0]  start_s;
  logic [5:0]  pick_s;
  logic        issue_s;
  logic [31:0] clr_s;

  // Returns {found, index} of the first set bit of vec scanning upward from start with wrap.
  // Scanning from the far end means the last hit written is the nearest one.
  function automatic logic [5:0] pick_first(input logic [31:0] vec, input logic [4:0] start);
    logic [5:0] res;
    logic [4:0] idx;
    res = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      idx = start + 5'(i);
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign load_s  = !out_valid_r || out_ready;
  assign elig_s  = pending_r & mask;
  assign start_s = (ROUND_ROBIN != 1'b0) ? ptr_r : 5'd0;
  assign pick_s  = pick_first(elig_s, start_s);
  assign issue_s = load_s && pick_s[5];

  // One-hot clear of the index issued on this edge.
  always_comb begin
    clr_s = 32'd0;
    if (issue_s) begin
      clr_s = 32'd1 << pick_s[4:0];
    end else begin
      clr_s = 32'd0;
    end
  end

  // Pending collection and lost-event detection; a new request outranks the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 32'd0;
      lost_r    <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | req;
      lost_r    <= |(req & pending_r & ~clr_s);
    end
  end

  // Output register: reload only when empty or accepted, otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= 5'd0;
    end else if (load_s) begin
      out_valid_r <= pick_s[5];
      if (pick_s[5]) begin
        out_idx_r <= pick_s[4:0];
      end else begin
        out_idx_r <= out_idx_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_idx_r   <= out_idx_r;
    end
  end

  // Rotating-priority pointer: one past the last issued index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 5'd0;
    end else if (issue_s) begin
      ptr_r <= pick_s[4:0] + 5'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign pending   = pending_r;
  assign lost      = lost_r;

endmodule

// File: tb/tb_encode32_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance, each with its own stimulus.
module tb_encode32_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_f, mask_f, pend_f;
  logic        rdy_f, vld_f, lost_f;
  logic [4:0]  idx_f;
  logic [31:0] req_r, mask_r, pend_r;
  logic        rdy_r, vld_r, lost_r;
  logic [4:0]  idx_r;

  int n_checks;
  int n_fail;

  encode32_arbiter #(.ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .mask(mask_f),
    .out_valid(vld_f), .out_ready(rdy_f), .out_idx(idx_f),
    .pending(pend_f), .lost(lost_f)
  );

  encode32_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .mask(mask_r),
    .out_valid(vld_r), .out_ready(rdy_r), .out_idx(idx_r),
    .pending(pend_r), .lost(lost_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full observable state of the fixed-priority instance.
  task automatic check_f(input string tag, input logic v, input logic [4:0] i,
                         input logic [31:0] p, input logic l);
    check({tag, ".valid"}, {31'd0, vld_f}, {31'd0, v});
    if (v) check({tag, ".idx"}, {27'd0, idx_f}, {27'd0, i});
    check({tag, ".pend"}, pend_f, p);
    check({tag, ".lost"}, {31'd0, lost_f}, {31'd0, l});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    req_f  = 32'hFFFF_FFFF; mask_f = 32'hFFFF_FFFF; rdy_f = 1'b1;
    req_r  = 32'hFFFF_FFFF; mask_r = 32'hFFFF_FFFF; rdy_r = 1'b1;

    // 1. Reset held with all requests active
    #1;
    for (int k = 0; k < 3; k++) begin
      check_f("rst_f", 1'b0, 5'd0, 32'd0, 1'b0);
      check("rst_r.valid", {31'd0, vld_r}, 32'd0);
      check("rst_r.pend", pend_r, 32'd0);
      check("rst_r.lost", {31'd0, lost_r}, 32'd0);
      tick();
    end
    check("rst.idx", {27'd0, idx_f}, 32'd0);
    req_f = 32'd0; req_r = 32'd0;
    rst_n = 1'b1;
    tick();
    tick();
    check_f("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    check("post_rst_r.valid", {31'd0, vld_r}, 32'd0);

    // 2. Single event on source 7
    req_f = 32'd1 << 7;
    tick();
    check_f("single.strobe", 1'b0, 5'd0, 32'h0000_0080, 1'b0);
    req_f = 32'd0;
    tick();
    check_f("single.issue", 1'b1, 5'd7, 32'd0, 1'b0);
    tick();
    check_f("single.idle", 1'b0, 5'd0, 32'd0, 1'b0);
    check("single.idx_hold", {27'd0, idx_f}, 32'd7);

    // 3. Fixed priority order 0, 4, 31
    req_f = 32'h8000_0011;
    tick();
    check_f("fixed.strobe", 1'b0, 5'd0, 32'h8000_0011, 1'b0);
    req_f = 32'd0;
    tick();
    check_f("fixed.0", 1'b1, 5'd0, 32'h8000_0010, 1'b0);
    tick();
    check_f("fixed.4", 1'b1, 5'd4, 32'h8000_0000, 1'b0);
    tick();
    check_f("fixed.31", 1'b1, 5'd31, 32'd0, 1'b0);
    tick();
    check_f("fixed.done", 1'b0, 5'd0, 32'd0, 1'b0);

    // 5. Backpressure and loss
    req_f = 32'd1 << 5;
    tick();
    req_f = 32'd0; rdy_f = 1'b0;
    tick();
    check_f("bp.issue5", 1'b1, 5'd5, 32'd0, 1'b0);
    req_f = 32'd1 << 9;
    tick();
    check_f("bp.first9", 1'b1, 5'd5, 32'h0000_0200, 1'b0);
    req_f = 32'd0;
    tick();
    check_f("bp.gap", 1'b1, 5'd5, 32'h0000_0200, 1'b0);
    req_f = 32'd1 << 9;
    tick();
    check_f("bp.second9", 1'b1, 5'd5, 32'h0000_0200, 1'b1);
    req_f = 32'd0;
    tick();
    check_f("bp.lost_pulse", 1'b1, 5'd5, 32'h0000_0200, 1'b0);
    rdy_f = 1'b1;
    tick();
    check_f("bp.issue9", 1'b1, 5'd9, 32'd0, 1'b0);
    tick();
    check_f("bp.once", 1'b0, 5'd0, 32'd0, 1'b0);

    // 6. Mask holds an event back; a re-request on the issuing edge stays pending
    mask_f = ~(32'd1 << 2);
    req_f  = 32'd1 << 2;
    tick();
    req_f = 32'd0;
    tick();
    tick();
    check_f("mask.held", 1'b0, 5'd0, 32'h0000_0004, 1'b0);
    mask_f = 32'hFFFF_FFFF;
    tick();
    check_f("mask.release", 1'b1, 5'd2, 32'd0, 1'b0);
    req_f = 32'd1 << 2;
    tick();
    check_f("coll.setup", 1'b0, 5'd0, 32'h0000_0004, 1'b0);
    tick();
    check_f("coll.edge", 1'b1, 5'd2, 32'h0000_0004, 1'b0);
    req_f = 32'd0;
    tick();
    check_f("coll.reissue", 1'b1, 5'd2, 32'd0, 1'b0);
    tick();
    check_f("coll.done", 1'b0, 5'd0, 32'd0, 1'b0);

    // 4. Round robin alternation and pointer wrap
    req_r = (32'd1 << 3) | (32'd1 << 20);
    tick();
    check("rr.strobe.valid", {31'd0, vld_r}, 32'd0);
    check("rr.strobe.pend", pend_r, 32'h0010_0008);
    tick();
    check("rr.a3", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd3});
    tick();
    check("rr.a20", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd20});
    tick();
    check("rr.b3", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd3});
    tick();
    check("rr.b20", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd20});
    req_r = 32'd0;
    tick();
    check("rr.c3", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd3});
    tick();
    check("rr.c20", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd20});
    tick();
    check("rr.drain", {31'd0, vld_r}, 32'd0);
    req_r = 32'd1 << 31;
    tick();
    req_r = (32'd1 << 31) | (32'd1 << 2);
    tick();
    check("rr.w31", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd31});
    check("rr.w31.pend", pend_r, 32'h8000_0004);
    req_r = 32'd0;
    tick();
    check("rr.wrap2", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd2});
    tick();
    check("rr.then31", {26'd0, vld_r, idx_r}, {26'd0, 1'b1, 5'd31});

    // Mid-operation reset drops pending and held output
    rdy_f = 1'b0;
    req_f = 32'h0000_0300;
    tick();
    req_f = 32'd0;
    tick();
    check_f("mid.before", 1'b1, 5'd8, 32'h0000_0200, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_f("mid.reset", 1'b0, 5'd0, 32'd0, 1'b0);
    check("mid.idx", {27'd0, idx_f}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
